// File: rtl/sdr_wr_data_buf.sv
// ---------------------------------------------------------------------------
// sdr_wr_data_buf
//
// Write-data staging buffer that sits directly upstream of the SDRAM
// data-path stage. Host words and byte masks are queued in a small FIFO and
// released as a registered burst of BURST_LEN beats when the command path
// pulses BURST_START. Beats that find the FIFO empty are fully masked so the
// SDRAM never writes stale data, and they raise the sticky UNDERRUN flag.
//
// Optional feature (compile-time macro SDR_WBUF_FILL_LEVEL_EN):
//   defined   -> adds output FILL_LEVEL, the registered FIFO occupancy.
//   undefined -> FILL_LEVEL and its logic are absent.
//
// Ports:
//   CLK           system clock, rising edge
//   RESET         synchronous, active-high reset
//   WR_VALID      host word present
//   WR_DATA       host write data
//   WR_DM         host byte mask (1 = byte not written)
//   WR_READY      FIFO can accept a word (low during reset)
//   BURST_START   one-cycle pulse: begin a burst
//   BURST_LEN     beats in the burst, 1..8, sampled with BURST_START
//   DATAOUT       registered beat data to the data path
//   DMOUT         registered beat mask to the data path
//   BURST_ACTIVE  high in every beat cycle
//   BURST_DONE    high in the last beat cycle
//   UNDERRUN      sticky underrun flag
//   CLR_ERR       clears UNDERRUN (a same-cycle underrun wins)
//   fsm_state     current controller state (0 = IDLE, 1 = BURST)
//   FILL_LEVEL    FIFO occupancy (only with SDR_WBUF_FILL_LEVEL_EN)
//
// Handshake: a host word is transferred on every rising edge where
// WR_VALID && WR_READY; WR_READY does not depend on WR_VALID.
// ---------------------------------------------------------------------------
module sdr_wr_data_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int PTR_BITS   = 3
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    WR_VALID,
   input  logic [DATA_WIDTH-1:0]   WR_DATA,
   input  logic [DATA_WIDTH/8-1:0] WR_DM,
   output logic                    WR_READY,
   input  logic                    BURST_START,
   input  logic [3:0]              BURST_LEN,
   output logic [DATA_WIDTH-1:0]   DATAOUT,
   output logic [DATA_WIDTH/8-1:0] DMOUT,
   output logic                    BURST_ACTIVE,
   output logic                    BURST_DONE,
   output logic                    UNDERRUN,
   input  logic                    CLR_ERR,
   output logic [0:0]              fsm_state
`ifdef SDR_WBUF_FILL_LEVEL_EN
   ,
   output logic [PTR_BITS:0]       FILL_LEVEL
`endif
);

   localparam int MASK_W = DATA_WIDTH / 8;
   localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [MASK_W-1:0]     mem_dm   [DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr;
   logic [PTR_BITS-1:0]   rd_ptr;
   logic [PTR_BITS:0]     count;

   logic [0:0] state;
   logic [3:0] beat_cnt;

   logic push;
   logic pop;
   logic beat;
   logic underrun_now;
   logic len_ok;

   assign WR_READY     = !RESET && (count != FULL_COUNT);
   assign push         = WR_VALID && WR_READY;
   assign beat         = (state == BURST);
   // No bypass: occupancy before the edge decides, so a word pushed in the
   // same cycle as a beat on an empty FIFO is not seen by that beat.
   assign pop          = beat && (count != '0);
   assign underrun_now = beat && (count == '0);
   assign len_ok       = (BURST_LEN != 4'd0) && (BURST_LEN <= 4'd8);
   assign fsm_state    = state;

`ifdef SDR_WBUF_FILL_LEVEL_EN
   assign FILL_LEVEL = count;
`endif

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_data[wr_ptr] <= WR_DATA;
         mem_dm[wr_ptr]   <= WR_DM;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         state        <= IDLE;
         beat_cnt     <= '0;
         DATAOUT      <= '0;
         DMOUT        <= '1;
         BURST_ACTIVE <= 1'b0;
         BURST_DONE   <= 1'b0;
         UNDERRUN     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         BURST_ACTIVE <= beat;
         BURST_DONE   <= beat && (beat_cnt == 4'd1);

         // DATAOUT holds on underrun beats and outside bursts; the mask
         // alone protects the SDRAM there.
         if (pop) begin
            DATAOUT <= mem_data[rd_ptr];
            DMOUT   <= mem_dm[rd_ptr];
         end else begin
            DMOUT   <= '1;
         end

         if (underrun_now)  UNDERRUN <= 1'b1;
         else if (CLR_ERR)  UNDERRUN <= 1'b0;

         case (state)
            IDLE: begin
               if (BURST_START && len_ok) begin
                  state    <= BURST;
                  beat_cnt <= BURST_LEN;
               end
            end
            default: begin
               // BURST_START is ignored here; the loaded length runs out.
               beat_cnt <= beat_cnt - 1'b1;
               if (beat_cnt == 4'd1) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sdr_wr_data_buf.md
Name: sdr_wr_data_buf

Overview:
- Write-data staging buffer directly upstream of the SDRAM data-path stage.
- Accepts host write words and byte masks through a valid/ready handshake and stores them in a small FIFO.
- When the command path signals the start of a write burst, it releases exactly BURST_LEN beats on consecutive cycles as registered DATAOUT/DMOUT, which feed the data-path DATAIN/DM.
- Underrun beats are masked so the SDRAM never writes stale data.

Parameters:
- DATA_WIDTH, 32, width of data word; must be a multiple of 8.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTR_BITS, 3, log2(DEPTH).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- WR_VALID  input  1  host word present.
- WR_DATA  input  DATA_WIDTH  host write data.
- WR_DM  input  DATA_WIDTH/8  host byte mask; 1 = byte not written.
- WR_READY  output  1  FIFO can accept a word.
- BURST_START  input  1  single-cycle pulse from command path: begin a burst.
- BURST_LEN  input  4  beats in the burst, 1..8; sampled with BURST_START.
- DATAOUT  output  DATA_WIDTH  beat data to data path.
- DMOUT  output  DATA_WIDTH/8  beat mask to data path.
- BURST_ACTIVE  output  1  high while beats are being driven.
- BURST_DONE  output  1  one-cycle pulse coincident with the last beat.
- UNDERRUN  output  1  sticky error flag.
- CLR_ERR  input  1  clears UNDERRUN.

Behaviour:
- Reset values:
  - DATAOUT = 0, DMOUT = all ones, WR_READY = 0 during reset.
  - BURST_ACTIVE = 0, BURST_DONE = 0, UNDERRUN = 0.
  - FIFO empty; state IDLE.
  - RESET mid-burst aborts the burst and flushes the FIFO.
- FIFO:
  - Occupancy count is PTR_BITS+1 bits; pointers wrap modulo DEPTH.
  - WR_READY = (count != DEPTH) when not in reset.
  - A push occurs when WR_VALID && WR_READY.
  - A pop occurs on each burst beat while count != 0.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - No bypass: a word pushed in cycle n is poppable at n+1 at the earliest. A push into an empty FIFO in the same cycle as a beat therefore underruns.
- State machine, IDLE -> BURST -> IDLE:
  - IDLE: on BURST_START with BURST_LEN in 1..8, load beat counter = BURST_LEN and go to BURST.
  - IDLE: BURST_LEN of 0 or greater than 8 is ignored and the block stays in IDLE.
  - BURST: each cycle, drive one beat and decrement the counter. When the counter is 1, assert BURST_DONE for that cycle and return to IDLE.
  - BURST_START while in BURST is ignored.
- Latency:
  - BURST_START sampled at edge n; beats appear on DATAOUT/DMOUT (registered) after edges n+1 .. n+BURST_LEN.
  - BURST_ACTIVE is high exactly in those cycles.
  - BURST_DONE is high in the last of those cycles.
  - Back-to-back bursts are possible: a new BURST_START may arrive in the BURST_DONE cycle. It is sampled in IDLE at the following edge and gives one idle cycle between bursts.
- Beat contents:
  - FIFO non-empty: DATAOUT = head data, DMOUT = head mask; pop.
  - FIFO empty: DATAOUT holds its previous value, DMOUT = all ones, no pop, UNDERRUN set. The burst still completes its full length.
- Outside a burst: DMOUT = all ones and DATAOUT holds.
- UNDERRUN: sticky until CLR_ERR. If CLR_ERR and a new underrun occur in the same cycle, the set wins.

Optional Feature:
- Macro: SDR_WBUF_FILL_LEVEL_EN.
- Defined: adds output port FILL_LEVEL (PTR_BITS+1 bits), equal to the registered FIFO occupancy. The command path uses it to delay BURST_START until FILL_LEVEL >= BURST_LEN.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: assert RESET with WR_VALID=1.
  - Required: WR_READY=0, DMOUT=4'hF, DATAOUT=0, no push.
  - Then: release RESET, push 8 words A0..A7; WR_READY drops after the 8th push.
- Burst of 4:
  - Stimulus: FIFO holds A0..A7 with masks 0; pulse BURST_START, BURST_LEN=4.
  - Required: DATAOUT = A0..A3 on 4 consecutive cycles; BURST_DONE with A3; DMOUT=0 during beats and 4'hF after.
  - With the macro defined: FILL_LEVEL=4 afterwards.
- Underrun:
  - Stimulus: 2 words in FIFO, BURST_LEN=4.
  - Required: beats 3 and 4 have DMOUT=4'hF and DATAOUT = beat-2 value; UNDERRUN=1 and sticky; CLR_ERR clears it.
- Full FIFO, concurrent push/pop:
  - Stimulus: FIFO full, burst popping while host holds WR_VALID.
  - Required: one push per freed slot, no word lost or duplicated; FIFO order is preserved across pointer wrap.
- Illegal and overlapping starts:
  - Stimulus: BURST_LEN=0 -> required: no BURST_ACTIVE.
  - Stimulus: BURST_START during an active burst -> required: ignored, burst length unchanged.
  - Stimulus: BURST_START in the BURST_DONE cycle -> required: next burst starts after one idle cycle.
- Mid-burst reset:
  - Stimulus: RESET during beat 2 of 8.
  - Required: BURST_ACTIVE=0 and FIFO empty next cycle; DMOUT=4'hF.
